inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Fetch unit on the requester side of the instruction ROM. Holds the PC, drives the ROM address and
//   captures the combinational ROM word into a one-entry instruction register (IR). Presents the IR
//   to decode via a valid/ready handshake. Supports branch redirect and halts on a halt opcode.
// PARAMETERS
//   ADDR_W     8      PC / ROM address width
//   INST_W     8      instruction width
//   RESET_PC   8'h00  PC value after reset
//   HALT_INST  8'hFF  opcode that halts fetch (ROM default word)
// PORTS
//   clk              in   1       clock, all state on rising edge
//   reset            in   1       synchronous, active-high reset
//   start_i          in   1       leave IDLE and begin fetching
//   address_o        out  ADDR_W  ROM address (= PC, combinational from PC register)
//   instruction_i    in   INST_W  ROM data, valid in same cycle as address_o
//   branch_i         in   1       redirect request (1-cycle pulse)
//   branch_target_i  in   ADDR_W  redirect address
//   inst_o           out  INST_W  IR contents
//   pc_o             out  ADDR_W  address from which inst_o was fetched
//   valid_o          out  1       IR holds an unconsumed instruction
//   ready_i          in   1       decode accepts inst_o when valid_o & ready_i
//   halted_o         out  1       FSM is in HALT
// BEHAVIOUR
//   - Reset (sync, high): PC<=RESET_PC, state<=IDLE, valid_o=0, inst_o=0, pc_o=0, halted_o=0.
//     Reset overrides every other input, including mid-fetch or mid-branch.
//   - FSM states: IDLE, RUN, HALT.
//     IDLE: no fetch, valid_o=0; start_i=1 -> RUN next cycle. branch_i is ignored in IDLE.
//     RUN: load when (!valid_o || ready_i): IR<=instruction_i, pc_o<=PC, valid_o<=1, PC<=PC+1.
//       If no load (valid_o & !ready_i), PC, IR and valid_o hold (stall).
//       If the loaded word == HALT_INST, it is still presented (valid) and state -> HALT, PC holds.
//     HALT: halted_o=1, no further loads; once IR accepted, valid_o<=0. Stays until reset or branch_i.
//   - Branch (RUN or HALT): branch_i=1 -> PC<=branch_target_i, valid_o<=0 (IR flushed, any
//     handshake that cycle is still counted as accepted by decode), no load that cycle, state->RUN.
//     The first instruction from target is valid the following cycle. Branch beats halt detection
//     and stall in the same cycle.
//   - Latency: PC to valid_o = 1 cycle. With ready_i held 1, one instruction per cycle.
//   - PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 -> 8'h00, no flag.
//   - inst_o/pc_o are stable whenever valid_o & !ready_i (decode may sample any cycle).
// CONFIGURATION
//   FETCH_COUNT_EN defined: adds output fetch_count_o [15:0], increments on every accepted
//     handshake (valid_o & ready_i), saturates at 16'hFFFF, cleared by reset only.
//   FETCH_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (ROM: addr n -> n for n=0..4, else 8'hFF)
//   1 reset, start_i pulse, ready_i=1 -> inst_o 00,01,02,03,04 on consecutive cycles, then FF with
//     halted_o=1; valid_o drops after FF accepted; address_o stays 05.
//   2 ready_i=0 for 3 cycles while inst_o=02 valid -> inst_o/pc_o hold 02, address_o holds 03;
//     ready_i=1 -> 03 next.
//   3 branch_i with target 8'h01 while IR=03 valid -> valid_o=0 next cycle, then inst_o=01, pc_o=01.
//   4 in HALT, branch_i target 8'h00 -> halted_o=0, fetch resumes 00,01,...
//   5 branch_target_i=8'hFF -> inst_o FF at pc_o FF, HALT, address_o holds FF (no 00 wrap fetch);
//     PC wrap checked by forcing RUN with ROM word !=HALT_INST at FF -> next address_o=00.
//   6 reset asserted mid-stall and in HALT -> all outputs 0, state IDLE; with FETCH_COUNT_EN,
//     count after scenario 1 = 6 and is cleared by reset.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: PC/ROM fetch unit with one-entry IR, valid/ready output, branch redirect and halt detection.
// Define FETCH_COUNT_EN to add a saturating accepted-instruction counter on fetch_count_o.
module inst_fetch #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [INST_W-1:0] HALT_INST = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic [ADDR_W-1:0] address_o,
  input  logic [INST_W-1:0] instruction_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i,
`ifdef FETCH_COUNT_EN
  output logic [15:0]       fetch_count_o,
`endif
  output logic              halted_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [1:0] state;
  logic [ADDR_W-1:0] pc;
  assign address_o = pc;
  assign halted_o = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      valid_o <= 1'b0;
      inst_o <= '0;
      pc_o <= '0;
    end else if (branch_i && state != IDLE) begin
      pc <= branch_target_i;
      valid_o <= 1'b0;
      state <= RUN;
    end else if (state == IDLE) begin
      if (start_i) state <= RUN;
    end else if (state == RUN) begin
      if (!valid_o || ready_i) begin
        inst_o <= instruction_i;
        pc_o <= pc;
        valid_o <= 1'b1;
        if (instruction_i == HALT_INST) state <= HALT;
        else pc <= pc + ADDR_W'(1);
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end
`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) fetch_count_o <= '0;
    else if (valid_o && ready_i && fetch_count_o != 16'hFFFF) fetch_count_o <= fetch_count_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenario bench for inst_fetch against a small ROM (n -> n for n<=4, else FF).
module tb_inst_fetch;
  logic clk = 0, reset = 1, start_i = 0, branch_i = 0, ready_i = 0, patch = 0;
  logic [7:0] address_o, instruction_i, branch_target_i = 0, inst_o, pc_o;
  logic valid_o, halted_o;
  logic [25:0] obs;
  int checks = 0, errors = 0;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_o;
`endif
  inst_fetch dut (
    .clk(clk), .reset(reset), .start_i(start_i), .address_o(address_o),
    .instruction_i(instruction_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
`ifdef FETCH_COUNT_EN
    .fetch_count_o(fetch_count_o),
`endif
    .halted_o(halted_o)
  );
  always #5 clk = ~clk;
  // patch replaces the halt word at FF so the PC wrap can be observed
  assign instruction_i = (patch && address_o == 8'hFF) ? 8'h55 : (address_o <= 8'h04 ? address_o : 8'hFF);
  assign obs = {halted_o, valid_o, inst_o, pc_o, address_o};
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_obs(input string name, input logic [25:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got h=%b v=%b inst=%h pc=%h addr=%h expected h=%b v=%b inst=%h pc=%h addr=%h",
        name, obs[25], obs[24], obs[23:16], obs[15:8], obs[7:0], exp[25], exp[24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask
  task automatic test_reset;
    reset = 1;
    step;
    step;
    expect_obs("reset", {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    reset = 0;
  endtask
  task automatic test_run_to_halt;
    start_i = 1;
    ready_i = 1;
    step;
    start_i = 0;
    expect_obs("start_latency", {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    for (int i = 0; i < 5; i++) begin
      step;
      expect_obs("seq", {1'b0, 1'b1, 8'(i), 8'(i), 8'(i + 1)});
    end
    step;
    expect_obs("halt_word", {1'b1, 1'b1, 8'hFF, 8'h05, 8'h05});
    step;
    expect_obs("halt_drain", {1'b1, 1'b0, 8'hFF, 8'h05, 8'h05});
`ifdef FETCH_COUNT_EN
    checks++;
    if (fetch_count_o !== 16'd6) begin
      errors++;
      $display("FAIL count_after_run: got %0d expected 6", fetch_count_o);
    end
`endif
  endtask
  task automatic test_halt_branch;
    branch_i = 1;
    branch_target_i = 8'h00;
    step;
    branch_i = 0;
    expect_obs("halt_branch", {1'b0, 1'b0, 8'hFF, 8'h05, 8'h00});
    for (int i = 0; i < 3; i++) begin
      step;
      expect_obs("resume", {1'b0, 1'b1, 8'(i), 8'(i), 8'(i + 1)});
    end
  endtask
  task automatic test_stall;
    ready_i = 0;
    repeat (3) begin
      step;
      expect_obs("stall_hold", {1'b0, 1'b1, 8'h02, 8'h02, 8'h03});
    end
    ready_i = 1;
    step;
    expect_obs("stall_release", {1'b0, 1'b1, 8'h03, 8'h03, 8'h04});
  endtask
  task automatic test_branch;
    ready_i = 0;
    branch_i = 1;
    branch_target_i = 8'h01;
    step;
    branch_i = 0;
    ready_i = 1;
    expect_obs("branch_flush", {1'b0, 1'b0, 8'h03, 8'h03, 8'h01});
    step;
    expect_obs("branch_target", {1'b0, 1'b1, 8'h01, 8'h01, 8'h02});
  endtask
  task automatic test_wrap;
    branch_i = 1;
    branch_target_i = 8'hFF;
    step;
    branch_i = 0;
    expect_obs("to_ff", {1'b0, 1'b0, 8'h01, 8'h01, 8'hFF});
    step;
    expect_obs("ff_halt", {1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    step;
    expect_obs("ff_hold", {1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF});
    patch = 1;
    branch_i = 1;
    step;
    branch_i = 0;
    expect_obs("ff_rebranch", {1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF});
    step;
    expect_obs("wrap", {1'b0, 1'b1, 8'h55, 8'hFF, 8'h00});
    step;
    expect_obs("after_wrap", {1'b0, 1'b1, 8'h00, 8'h00, 8'h01});
    patch = 0;
  endtask
  task automatic test_reset_mid;
    ready_i = 0;
    step;
    expect_obs("pre_reset_stall", {1'b0, 1'b1, 8'h00, 8'h00, 8'h01});
    reset = 1;
    step;
    expect_obs("reset_mid_stall", {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
`ifdef FETCH_COUNT_EN
    checks++;
    if (fetch_count_o !== 16'd0) begin
      errors++;
      $display("FAIL count_reset: got %0d expected 0", fetch_count_o);
    end
`endif
    reset = 0;
    ready_i = 1;
    branch_i = 1;
    branch_target_i = 8'h03;
    step;
    branch_i = 0;
    expect_obs("idle_ignores_branch", {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    step;
    expect_obs("idle_stays", {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    start_i = 1;
    step;
    start_i = 0;
    repeat (6) step;
    expect_obs("rerun_halt", {1'b1, 1'b1, 8'hFF, 8'h05, 8'h05});
    reset = 1;
    step;
    expect_obs("reset_in_halt", {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    reset = 0;
  endtask
  initial begin
    test_reset;
    test_run_to_halt;
    test_halt_branch;
    test_stall;
    test_branch;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
